// File: rtl/ccip_hello_line_writer_pkg.sv
// Shared types for the hello line writer: a trimmed CCI-P channel view,
// CSR map, DFH constant and the run-state enum.
package ccip_hello_line_writer_pkg;

    // ---------------- trimmed CCI-P types ----------------
    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRFENCE  = 4'h4
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4
    } t_ccip_c1_rsp;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_rsp resp_type;
        logic         format;
        logic [1:0]   cl_num;
        logic [15:0]  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [41:0] address;
        logic [15:0] mdata;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_req req_type;
        logic [41:0]  address;
        t_ccip_clLen  cl_len;
        logic         sop;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0]  tid;
        logic [63:0] data;
        logic        mmioRdValid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    // ---------------- CSR map (32b-word addresses) ----------------
    localparam logic [15:0] CSR_DFH       = 16'h0000;
    localparam logic [15:0] CSR_AFU_ID_L  = 16'h0002;
    localparam logic [15:0] CSR_AFU_ID_H  = 16'h0004;
    localparam logic [15:0] CSR_BUF_ADDR  = 16'h0010;
    localparam logic [15:0] CSR_NUM_LINES = 16'h0012;
    localparam logic [15:0] CSR_CTRL      = 16'h0014;
    localparam logic [15:0] CSR_STATUS    = 16'h0016;

    // Standard 64-bit DFH layout: type AFU at [63:60], end-of-list at [40].
    localparam logic [63:0] AFU_DFH = {4'h1, 8'h0, 4'h0, 7'h0, 1'b1,
                                       24'h0, 4'h0, 12'h0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FENCE = 2'd2,
        WAIT  = 2'd3
    } t_state;

endpackage

// File: rtl/ccip_hello_line_writer_csr.sv
// MMIO decode and readback for the line writer.
// Ports: clk/reset_n; mmio_i (c0 MMIO rx); busy_i/done_i/acks_i status in;
// buf_addr_o/num_lines_o/start_o config out; c2_o registered MMIO read rsp.
module ccip_hello_line_writer_csr
    import ccip_hello_line_writer_pkg::*;
#(
    parameter logic [63:0] AFU_ID_H = 64'h0,
    parameter logic [63:0] AFU_ID_L = 64'h0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  t_if_ccip_c0_Rx   mmio_i,
    input  logic             busy_i,
    input  logic             done_i,
    input  logic [CNT_W-1:0] acks_i,
    output logic [41:0]      buf_addr_o,
    output logic [CNT_W-1:0] num_lines_o,
    output logic             start_o,
    output t_if_ccip_c2_Tx   c2_o
);

    logic [41:0]      buf_addr_q;
    logic [CNT_W-1:0] num_lines_q;
    logic             start_q;
    t_if_ccip_c2_Tx   c2_q;
    logic [63:0]      rd_data;
    logic             locked;
    logic             unused_mmio;

    // A start already in flight locks the config like a running job.
    assign locked = busy_i | start_q;

    assign unused_mmio = ^{mmio_i.hdr.length, mmio_i.data[511:42]};

    always_comb begin
        rd_data = '0;
        unique case (mmio_i.hdr.address)
            CSR_DFH:       rd_data = AFU_DFH;
            CSR_AFU_ID_L:  rd_data = AFU_ID_L;
            CSR_AFU_ID_H:  rd_data = AFU_ID_H;
            CSR_BUF_ADDR:  rd_data = 64'(buf_addr_q);
            CSR_NUM_LINES: rd_data = 64'(num_lines_q);
            CSR_STATUS:    rd_data = {32'(acks_i), 30'h0, done_i, busy_i};
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_addr_q  <= '0;
            num_lines_q <= '0;
            start_q     <= 1'b0;
            c2_q        <= '0;
        end else begin
            start_q          <= 1'b0;
            c2_q.mmioRdValid <= mmio_i.mmioRdValid;
            if (mmio_i.mmioRdValid) begin
                c2_q.tid  <= mmio_i.hdr.tid;
                c2_q.data <= rd_data;
            end
            if (mmio_i.mmioWrValid && !locked) begin
                unique case (mmio_i.hdr.address)
                    CSR_BUF_ADDR:  buf_addr_q  <= mmio_i.data[41:0];
                    CSR_NUM_LINES: num_lines_q <= mmio_i.data[CNT_W-1:0];
                    CSR_CTRL:      start_q     <= mmio_i.data[0];
                    default:       ;
                endcase
            end
        end
    end

    assign buf_addr_o  = buf_addr_q;
    assign num_lines_o = num_lines_q;
    assign start_o     = start_q;
    assign c2_o        = c2_q;

endmodule

// File: rtl/ccip_hello_line_writer.sv
// AFU body: writes NUM_LINES pattern lines from BUF_ADDR, fences, flags done.
// Ports: clk, reset_n, cp2af_sRx (MMIO + write rsp), af2cp_sTx (c1 writes,
// c2 MMIO rsp; c0 idle), busy (run in progress).
module ccip_hello_line_writer
    import ccip_hello_line_writer_pkg::*;
#(
    parameter logic [63:0] AFU_ID_H = 64'h0,
    parameter logic [63:0] AFU_ID_L = 64'h0,
    parameter int          CNT_W    = 16,
    parameter logic [63:0] PATTERN  = 64'h6F57_206F_6C6C_6548
) (
    input  logic        clk,
    input  logic        reset_n,
    input  t_if_ccip_Rx cp2af_sRx,
    output t_if_ccip_Tx af2cp_sTx,
    output logic        busy
);

    t_state           state_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] acks_q;
    logic             done_q;
    logic             busy_q;
    logic             fence_seen_q;
    t_if_ccip_c1_Tx   c1_q;

    logic [41:0]      buf_addr;
    logic [CNT_W-1:0] num_lines;
    logic [CNT_W-1:0] last_idx;
    logic             start;
    t_if_ccip_c2_Tx   c2;
    logic             alm_full;
    logic             wr_ack;
    logic             fence_ack;
    logic [CNT_W-1:0] ack_inc;
    logic             unused_rsp;

    ccip_hello_line_writer_csr #(
        .AFU_ID_H (AFU_ID_H),
        .AFU_ID_L (AFU_ID_L),
        .CNT_W    (CNT_W)
    ) u_csr (
        .clk         (clk),
        .reset_n     (reset_n),
        .mmio_i      (cp2af_sRx.c0),
        .busy_i      (busy_q),
        .done_i      (done_q),
        .acks_i      (acks_q),
        .buf_addr_o  (buf_addr),
        .num_lines_o (num_lines),
        .start_o     (start),
        .c2_o        (c2)
    );

    assign alm_full  = cp2af_sRx.c1TxAlmFull;
    assign last_idx  = num_lines - CNT_W'(1);
    assign wr_ack    = cp2af_sRx.c1.rspValid &&
                       cp2af_sRx.c1.hdr.resp_type == eRSP_WRLINE;
    assign fence_ack = cp2af_sRx.c1.rspValid &&
                       cp2af_sRx.c1.hdr.resp_type == eRSP_WRFENCE;
    // Packed acks cover cl_num+1 lines in one response.
    assign ack_inc   = cp2af_sRx.c1.hdr.format ?
                       CNT_W'(cp2af_sRx.c1.hdr.cl_num) + CNT_W'(1) :
                       CNT_W'(1);
    assign unused_rsp = ^cp2af_sRx.c1.hdr.mdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acks_q       <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            fence_seen_q <= 1'b0;
            c1_q         <= '0;
        end else begin
            c1_q.valid <= 1'b0;
            if (busy_q && wr_ack) begin
                acks_q <= acks_q + ack_inc;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        done_q       <= 1'b0;
                        idx_q        <= '0;
                        acks_q       <= '0;
                        fence_seen_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= (num_lines == '0) ? FENCE : WRITE;
                    end
                end
                WRITE: begin
                    if (!alm_full) begin
                        c1_q.valid         <= 1'b1;
                        c1_q.hdr.req_type  <= eREQ_WRLINE_I;
                        c1_q.hdr.address   <= buf_addr + 42'(idx_q);
                        c1_q.hdr.cl_len    <= eCL_LEN_1;
                        c1_q.hdr.sop       <= 1'b1;
                        c1_q.hdr.mdata     <= 16'(idx_q);
                        c1_q.data          <= {PATTERN, 384'h0, 64'(idx_q)};
                        if (idx_q == last_idx) begin
                            state_q <= FENCE;
                        end else begin
                            idx_q <= idx_q + CNT_W'(1);
                        end
                    end
                end
                FENCE: begin
                    if (!alm_full) begin
                        c1_q.valid        <= 1'b1;
                        c1_q.hdr.req_type <= eREQ_WRFENCE;
                        c1_q.hdr.address  <= '0;
                        c1_q.hdr.cl_len   <= eCL_LEN_1;
                        c1_q.hdr.sop      <= 1'b0;
                        c1_q.hdr.mdata    <= '0;
                        c1_q.data         <= '0;
                        state_q           <= WAIT;
                    end
                end
                WAIT: begin
                    if (fence_ack) begin
                        fence_seen_q <= 1'b1;
                    end
                    // Fence ack may land before the last write ack is counted.
                    if ((fence_seen_q || fence_ack) && acks_q == num_lines) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        af2cp_sTx    = '0;
        af2cp_sTx.c1 = c1_q;
        af2cp_sTx.c2 = c2;
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_ccip_hello_line_writer.sv
// Self-checking bench: randomized runs against a queue-based reference model.
module tb_ccip_hello_line_writer;
    import ccip_hello_line_writer_pkg::*;

    localparam logic [63:0] ID_H = 64'hA5A5_0123_4567_89AB;
    localparam logic [63:0] ID_L = 64'h5A5A_FEDC_BA98_7654;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    t_if_ccip_Rx rx;
    t_if_ccip_Tx tx;
    logic        busy;

    ccip_hello_line_writer #(
        .AFU_ID_H (ID_H),
        .AFU_ID_L (ID_L)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cp2af_sRx (rx),
        .af2cp_sTx (tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    t_if_ccip_c1_Tx obs_q[$];
    int   c0_seen = 0;
    logic alm_edge = 1'b0;
    int   alm_extra = 0;
    int   alm_extra_max = 0;

    always @(posedge clk) alm_edge = rx.c1TxAlmFull;

    always @(negedge clk) begin
        if (tx.c0.valid) c0_seen++;
        if (tx.c1.valid) obs_q.push_back(tx.c1);
        if (alm_edge) begin
            if (tx.c1.valid) alm_extra++;
            if (alm_extra > alm_extra_max) alm_extra_max = alm_extra;
        end else begin
            alm_extra = 0;
        end
    end

    // ---------------- reference helpers ----------------
    logic [95:0] pat_full = 96'h0A646C726F57206F6C6C6548;
    logic [63:0] pat;

    function automatic logic [63:0] status_word(int n, bit d, bit b);
        return (64'(n) << 32) | (64'(d) << 1) | 64'(b);
    endfunction

    function automatic logic [41:0] line_addr(logic [41:0] base, int i);
        logic [63:0] s;
        s = (64'(base) + 64'(i)) % (64'd1 << 42);
        return s[41:0];
    endfunction

    // ---------------- drivers ----------------
    task automatic mmio_wr(logic [15:0] a, logic [63:0] d);
        @(negedge clk); #1;
        rx.c0.mmioWrValid = 1'b1;
        rx.c0.hdr.address = a;
        rx.c0.data = 512'(d);
        @(negedge clk); #1;
        rx.c0.mmioWrValid = 1'b0;
    endtask

    task automatic mmio_rd(string tag, logic [15:0] a, logic [8:0] tid,
                           logic [63:0] exp);
        @(negedge clk); #1;
        rx.c0.mmioRdValid = 1'b1;
        rx.c0.hdr.address = a;
        rx.c0.hdr.tid = tid;
        @(negedge clk);
        chk({tag, "_vld"}, 64'(tx.c2.mmioRdValid), 64'd1);
        chk({tag, "_tid"}, 64'(tx.c2.tid), 64'(tid));
        chk({tag, "_data"}, tx.c2.data, exp);
        #1 rx.c0.mmioRdValid = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_off"}, 64'(tx.c2.mmioRdValid), 64'd0);
    endtask

    task automatic send_rsp(t_ccip_c1_rsp t, bit fmt, logic [1:0] cl);
        @(negedge clk); #1;
        rx.c1.rspValid = 1'b1;
        rx.c1.hdr.resp_type = t;
        rx.c1.hdr.format = fmt;
        rx.c1.hdr.cl_num = cl;
        rx.c1.hdr.mdata = 16'h0;
        @(negedge clk); #1;
        rx.c1.rspValid = 1'b0;
    endtask

    task automatic send_acks(int n);
        int rem = n;
        int k;
        bit fmt;
        while (rem > 0) begin
            k = $urandom_range(1, rem < 4 ? rem : 4);
            fmt = (k > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            send_rsp(eRSP_WRLINE, fmt, 2'(k - 1));
            rem -= k;
        end
    endtask

    // alm_mode: 0 never full, 1 full for 10 cycles after 2nd line, 2 random
    task automatic run(string tag, logic [41:0] base, int n, int alm_mode,
                       bit poke);
        bit fence_seen = 1'b0;
        int alm_cnt = 0;
        t_if_ccip_c1_Tx r;
        obs_q.delete();
        alm_extra_max = 0;
        mmio_wr(16'h0010, 64'(base));
        mmio_wr(16'h0012, 64'(n));
        mmio_wr(16'h0014, 64'd1);
        if (poke) begin
            mmio_wr(16'h0012, 64'd2);
            mmio_wr(16'h0010, 64'h0);
            mmio_wr(16'h0014, 64'd1);
            mmio_rd({tag, "_nl_rb"}, 16'h0012, 9'h1A, 64'(n));
            mmio_rd({tag, "_ba_rb"}, 16'h0010, 9'h1B, 64'(base));
        end
        for (int c = 0; c < 400 && !fence_seen; c++) begin
            @(negedge clk); #1;
            if (obs_q.size() > 0)
                fence_seen = (obs_q[obs_q.size()-1].hdr.req_type == eREQ_WRFENCE);
            if (alm_mode == 1) begin
                if (obs_q.size() >= 2 && alm_cnt < 10) begin
                    rx.c1TxAlmFull = 1'b1;
                    alm_cnt++;
                end else begin
                    rx.c1TxAlmFull = 1'b0;
                end
            end else if (alm_mode == 2) begin
                rx.c1TxAlmFull = ($urandom_range(0, 3) == 0);
            end
        end
        rx.c1TxAlmFull = 1'b0;
        chk({tag, "_fence_seen"}, 64'(fence_seen), 64'd1);
        chk({tag, "_busy_wait"}, 64'(busy), 64'd1);
        chk({tag, "_nreq"}, 64'(obs_q.size()), 64'(n + 1));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            r = obs_q[i];
            chk({tag, "_addr"}, 64'(r.hdr.address), 64'(line_addr(base, i)));
            chk({tag, "_mdata"}, 64'(r.hdr.mdata), 64'(i));
            chk({tag, "_hdr"}, 64'({r.hdr.req_type, r.hdr.cl_len, r.hdr.sop}),
                64'({eREQ_WRLINE_I, eCL_LEN_1, 1'b1}));
            chk({tag, "_dhi"}, r.data[511:448], pat);
            chk({tag, "_dmid"}, 64'(|r.data[447:64]), 64'd0);
            chk({tag, "_dlo"}, r.data[63:0], 64'(i));
        end
        if (obs_q.size() == n + 1)
            chk({tag, "_last_fence"}, 64'(obs_q[n].hdr.req_type),
                64'(eREQ_WRFENCE));
        chk({tag, "_alm_extra"}, 64'(alm_extra_max <= 1), 64'd1);
        mmio_rd({tag, "_st_run"}, 16'h0016, 9'h05, status_word(0, 0, 1));
        send_acks(n);
        mmio_rd({tag, "_st_acked"}, 16'h0016, 9'h06, status_word(n, 0, 1));
        send_rsp(eRSP_WRFENCE, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        mmio_rd({tag, "_st_done"}, 16'h0016, 9'h07, status_word(n, 1, 0));
    endtask

    initial begin
        pat = pat_full[63:0];
        rx = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_c1_vld", 64'(tx.c1.valid), 64'd0);
        chk("rst_c2_vld", 64'(tx.c2.mmioRdValid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        #1 reset_n = 1'b1;

        mmio_rd("dfh", 16'h0000, 9'd5, (64'd1 << 60) | (64'd1 << 40));
        mmio_rd("id_l", 16'h0002, 9'd5, ID_L);
        mmio_rd("id_h", 16'h0004, 9'd5, ID_H);
        mmio_rd("unmapped", 16'h0030, 9'd5, 64'h0);
        mmio_rd("rsvd06", 16'h0006, 9'h1FF, 64'h0);
        mmio_rd("st_reset", 16'h0016, 9'd3, 64'h0);

        run("basic", 42'h1000, 4, 0, 1'b0);
        chk("basic_status", status_word(4, 1, 0), 64'h0000_0004_0000_0002);
        run("zero", 42'h2000, 0, 0, 1'b0);
        run("almfull", 42'h4000, 8, 1, 1'b0);
        run("wrap", 42'h3FF_FFFF_FFFE, 4, 0, 1'b0);
        run("busy_poke", 42'h5000, 6, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [41:0] b;
            b = {10'($urandom), 32'($urandom)};
            run("rnd", b, $urandom_range(0, 10), 2, 1'b0);
        end

        // reset in the middle of a write burst
        obs_q.delete();
        mmio_wr(16'h0010, 64'h8000);
        mmio_wr(16'h0012, 64'd8);
        mmio_wr(16'h0014, 64'd1);
        for (int c = 0; c < 20 && obs_q.size() < 2; c++) @(negedge clk);
        #1;
        chk("mid_vld_pre", 64'(tx.c1.valid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(tx.c1.valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        mmio_rd("post_st", 16'h0016, 9'd9, 64'h0);
        mmio_rd("post_ba", 16'h0010, 9'd9, 64'h0);
        mmio_rd("post_nl", 16'h0012, 9'd9, 64'h0);
        send_rsp(eRSP_WRLINE, 1'b1, 2'd3);
        send_rsp(eRSP_WRFENCE, 1'b0, 2'd0);
        mmio_rd("stale_st", 16'h0016, 9'd9, 64'h0);
        run("recover", 42'h100, 2, 0, 1'b0);

        chk("c0_never", 64'(c0_seen), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
